wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/rv32i_types.sv | 41 ++++
 rtl/wb_stage_load_align.sv | 38 +++
 rtl/wb_stage.sv | 95 +++++++++
 tb/tb_wb_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the RV32I writeback stage: FSM states, writeback control,
// load funct3 encodings and the MEM/WB pipeline register payload.
package rv32i_types;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    WAIT  = 2'd2
  } wb_state_t;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_BR  = 2'd1,
    WB_SEL_PC4 = 2'd2,
    WB_SEL_MEM = 2'd3
  } wb_sel_t;

  localparam logic [2:0] LD_F3_LB  = 3'b000;
  localparam logic [2:0] LD_F3_LH  = 3'b001;
  localparam logic [2:0] LD_F3_LW  = 3'b010;
  localparam logic [2:0] LD_F3_LBU = 3'b100;
  localparam logic [2:0] LD_F3_LHU = 3'b101;

  typedef struct packed {
    logic       regf_we;
    logic       is_load;
    wb_sel_t    wb_sel;
    logic [2:0] ld_funct3;
  } wb_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] order;
    wb_ctrl_t    wb_ctrl;
    logic [4:0]  rd_s;
    logic        br_en;
    logic [31:0] alu_out;
    logic [31:0] dmem_addr;
  } mem_wb_stage_reg_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Extracts and extends the loaded byte/halfword/word from the raw read word.
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unknown funct3 yields zero; the instruction still retires upstream of here.
  always_comb begin
    value = '0;
    case (funct3)
      LD_F3_LB:  value = {{24{byte_sel[7]}}, byte_sel};
      LD_F3_LBU: value = {24'd0, byte_sel};
      LD_F3_LH:  value = {{16{half_sel[15]}}, half_sel};
      LD_F3_LHU: value = {16'd0, half_sel};
      LD_F3_LW:  value = rdata;
      default:   value = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one MEM/WB payload, waits for load data if needed,
// retires it to the register file and counts retired instructions.
module wb_stage
  import rv32i_types::*;
#(
  parameter int CNT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wb_valid,
  input  mem_wb_stage_reg_t mem_wb_reg,
  output logic              wb_ready,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              rd_we,
  output logic [4:0]        rd_s,
  output logic [31:0]       rd_v,
  output logic              commit_valid,
  output logic [63:0]       commit_order,
  output logic [CNT_W-1:0]  retired_cnt,
  output wb_state_t         dbg_state
);

  wb_state_t         state_q, state_d;
  mem_wb_stage_reg_t hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        retire;
  logic        capture;
  logic [31:0] ld_val;
  logic [31:0] wb_val;
  logic        unused_addr_bits;

  // Handshake: payload moves on mem_wb_valid && wb_ready at the rising edge;
  // wb_ready drops only while a held load is still waiting for dmem_resp.
  assign wb_ready = (state_q != WAIT) || dmem_resp;
  assign capture  = mem_wb_valid && wb_ready;
  assign retire   = (state_q == HOLD) || ((state_q == WAIT) && dmem_resp);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (retire) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = EMPTY;
    end
    if (capture) begin
      hold_d  = mem_wb_reg;
      state_d = mem_wb_reg.wb_ctrl.is_load ? WAIT : HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .off    (hold_q.dmem_addr[1:0]),
    .funct3 (hold_q.wb_ctrl.ld_funct3),
    .value  (ld_val)
  );

  assign unused_addr_bits = ^hold_q.dmem_addr[31:2];

  always_comb begin
    wb_val = '0;
    case (hold_q.wb_ctrl.wb_sel)
      WB_SEL_ALU: wb_val = hold_q.alu_out;
      WB_SEL_BR:  wb_val = {31'd0, hold_q.br_en};
      WB_SEL_PC4: wb_val = hold_q.pc + 32'd4;
      WB_SEL_MEM: wb_val = ld_val;
      default:    wb_val = '0;
    endcase
  end

  // Outputs are forced to zero whenever nothing retires.
  assign commit_valid = retire;
  assign rd_we        = retire && hold_q.wb_ctrl.regf_we && (hold_q.rd_s != 5'd0);
  assign rd_s         = retire ? hold_q.rd_s : 5'd0;
  assign rd_v         = retire ? wb_val : 32'd0;
  assign commit_order = retire ? hold_q.order : 64'd0;
  assign retired_cnt  = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: vector table plus hand-written
// multi-cycle sequences for load stalls, back-to-back flow, reset and wrap.
module tb_wb_stage;
  import rv32i_types::*;

  logic              clk;
  logic              rst;
  logic              mem_wb_valid;
  mem_wb_stage_reg_t mem_wb_reg;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;

  logic              wb_ready, rd_we, commit_valid;
  logic [4:0]        rd_s;
  logic [31:0]       rd_v;
  logic [63:0]       commit_order, retired_cnt;
  wb_state_t         dbg_state;

  logic              w4_ready, w4_rd_we, w4_commit_valid;
  logic [4:0]        w4_rd_s;
  logic [31:0]       w4_rd_v;
  logic [63:0]       w4_commit_order;
  logic [3:0]        w4_retired_cnt;
  wb_state_t         w4_dbg_state;

  wb_stage dut (
    .clk(clk), .rst(rst), .mem_wb_valid(mem_wb_valid), .mem_wb_reg(mem_wb_reg),
    .wb_ready(wb_ready), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .rd_we(rd_we), .rd_s(rd_s), .rd_v(rd_v), .commit_valid(commit_valid),
    .commit_order(commit_order), .retired_cnt(retired_cnt), .dbg_state(dbg_state)
  );

  wb_stage #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .mem_wb_valid(mem_wb_valid), .mem_wb_reg(mem_wb_reg),
    .wb_ready(w4_ready), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .rd_we(w4_rd_we), .rd_s(w4_rd_s), .rd_v(w4_rd_v), .commit_valid(w4_commit_valid),
    .commit_order(w4_commit_order), .retired_cnt(w4_retired_cnt), .dbg_state(w4_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_cnt;
  logic [63:0] order_ctr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every commit must match the next expected order value.
  always @(negedge clk) begin
    #2;
    if (commit_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_commit: got order 0x%0h expected no commit", commit_order);
      end else begin
        check("commit_order", commit_order, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    wb_sel_t     sel;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        br;
    logic [31:0] alu;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_v;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic ld, logic [2:0] f3, wb_sel_t sel, logic we, logic [4:0] rd,
                              logic [31:0] pc, logic br, logic [31:0] alu, logic [31:0] addr,
                              logic [31:0] rdata, logic ewe, logic [31:0] ev);
    vec_t v;
    v.is_load = ld; v.f3 = f3; v.sel = sel; v.we = we; v.rd = rd; v.pc = pc; v.br = br;
    v.alu = alu; v.addr = addr; v.rdata = rdata; v.exp_we = ewe; v.exp_v = ev;
    return v;
  endfunction

  function automatic mem_wb_stage_reg_t mk_pl(vec_t v, logic [63:0] ord);
    mem_wb_stage_reg_t p;
    p = '0;
    p.pc = v.pc;
    p.order = ord;
    p.wb_ctrl.regf_we = v.we;
    p.wb_ctrl.is_load = v.is_load;
    p.wb_ctrl.wb_sel = v.sel;
    p.wb_ctrl.ld_funct3 = v.f3;
    p.rd_s = v.rd;
    p.br_en = v.br;
    p.alu_out = v.alu;
    p.dmem_addr = v.addr;
    return p;
  endfunction

  function automatic vec_t alu_op(logic [4:0] rd, logic [31:0] alu);
    return mk(1'b0, 3'd0, WB_SEL_ALU, 1'b1, rd, 32'h0, 1'b0, alu, 32'h0, 32'h0, rd != 5'd0, alu);
  endfunction

  // Driver: single transaction, captured then retired (loads get dmem_resp next cycle).
  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    mem_wb_valid = 1'b1;
    mem_wb_reg   = mk_pl(v, order_ctr);
    exp_q.push_back(order_ctr);
    order_ctr++;
    @(posedge clk);
    @(negedge clk);
    mem_wb_valid = 1'b0;
    mem_wb_reg   = '0;
    dmem_resp    = 1'b1;
    dmem_rdata   = v.rdata;
    #1;
    check({tag, "_commit_valid"}, 64'(commit_valid), 64'd1);
    check({tag, "_rd_we"}, 64'(rd_we), 64'(v.exp_we));
    check({tag, "_rd_s"}, 64'(rd_s), 64'(v.rd));
    check({tag, "_rd_v"}, 64'(rd_v), 64'(v.exp_v));
    check({tag, "_cnt_before"}, retired_cnt, exp_cnt);
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check({tag, "_cnt_after"}, retired_cnt, exp_cnt);
    check({tag, "_idle"}, 64'(commit_valid), 64'd0);
  endtask

  initial begin
    vecs[0]  = mk(0, 3'd0,      WB_SEL_ALU, 1, 5'd5,  32'h0,        0, 32'h1234, 32'h0,    32'hFFFFFFFF, 1, 32'h1234);
    vecs[1]  = mk(0, 3'd0,      WB_SEL_ALU, 1, 5'd0,  32'h0,        0, 32'hDEAD, 32'h0,    32'hFFFFFFFF, 0, 32'hDEAD);
    vecs[2]  = mk(0, 3'd0,      WB_SEL_BR,  1, 5'd7,  32'h0,        1, 32'h9999, 32'h0,    32'hFFFFFFFF, 1, 32'h1);
    vecs[3]  = mk(0, 3'd0,      WB_SEL_BR,  1, 5'd7,  32'h0,        0, 32'h9999, 32'h0,    32'hFFFFFFFF, 1, 32'h0);
    vecs[4]  = mk(0, 3'd0,      WB_SEL_PC4, 1, 5'd1,  32'hFFFFFFFC, 0, 32'h0,    32'h0,    32'hFFFFFFFF, 1, 32'h0);
    vecs[5]  = mk(0, 3'd0,      WB_SEL_PC4, 1, 5'd31, 32'h100,      0, 32'h0,    32'h0,    32'hFFFFFFFF, 1, 32'h104);
    vecs[6]  = mk(0, 3'd0,      WB_SEL_ALU, 0, 5'd3,  32'h0,        0, 32'h77,   32'h0,    32'hFFFFFFFF, 0, 32'h77);
    vecs[7]  = mk(1, LD_F3_LB,  WB_SEL_MEM, 1, 5'd8,  32'h0,        0, 32'h0,    32'h2003, 32'h80FFFFFF, 1, 32'hFFFFFF80);
    vecs[8]  = mk(1, LD_F3_LBU, WB_SEL_MEM, 1, 5'd8,  32'h0,        0, 32'h0,    32'h2003, 32'h80FFFFFF, 1, 32'h80);
    vecs[9]  = mk(1, LD_F3_LBU, WB_SEL_MEM, 1, 5'd8,  32'h0,        0, 32'h0,    32'h2001, 32'h12345678, 1, 32'h56);
    vecs[10] = mk(1, LD_F3_LB,  WB_SEL_MEM, 1, 5'd8,  32'h0,        0, 32'h0,    32'h2000, 32'h12345678, 1, 32'h78);
    vecs[11] = mk(1, LD_F3_LHU, WB_SEL_MEM, 1, 5'd9,  32'h0,        0, 32'h0,    32'h2002, 32'hBEEF0000, 1, 32'h0000BEEF);
    vecs[12] = mk(1, LD_F3_LH,  WB_SEL_MEM, 1, 5'd9,  32'h0,        0, 32'h0,    32'h2002, 32'hBEEF0000, 1, 32'hFFFFBEEF);
    vecs[13] = mk(1, LD_F3_LH,  WB_SEL_MEM, 1, 5'd9,  32'h0,        0, 32'h0,    32'h2000, 32'h00007FFF, 1, 32'h7FFF);
    vecs[14] = mk(1, LD_F3_LW,  WB_SEL_MEM, 1, 5'd9,  32'h0,        0, 32'h0,    32'h2000, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    vecs[15] = mk(1, 3'b011,    WB_SEL_MEM, 1, 5'd9,  32'h0,        0, 32'h0,    32'h2000, 32'hFFFFFFFF, 1, 32'h0);
    vecs[16] = mk(1, LD_F3_LW,  WB_SEL_MEM, 1, 5'd0,  32'h0,        0, 32'h0,    32'h2000, 32'h11112222, 0, 32'h11112222);

    rst = 1'b0; mem_wb_valid = 1'b0; mem_wb_reg = '0; dmem_rdata = '0; dmem_resp = 1'b0;
    exp_cnt = '0; order_ctr = 64'h100;

    // Reset values, and no capture while held in reset
    #1;
    check("rst_wb_ready", 64'(wb_ready), 64'd1);
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_rd_we", 64'(rd_we), 64'd0);
    check("rst_rd_s", 64'(rd_s), 64'd0);
    check("rst_rd_v", 64'(rd_v), 64'd0);
    check("rst_commit_order", commit_order, 64'd0);
    check("rst_retired_cnt", retired_cnt, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(EMPTY));
    @(negedge clk);
    mem_wb_valid = 1'b1;
    mem_wb_reg   = mk_pl(alu_op(5'd2, 32'hABCD), 64'h55);
    @(posedge clk); #1;
    check("rst_no_capture", 64'(commit_valid), 64'd0);
    check("rst_hold_state", 64'(dbg_state), 64'(EMPTY));
    @(negedge clk);
    mem_wb_valid = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 17; i++) apply_vec(vecs[i], i);

    // lb with dmem_resp delayed 3 cycles, next op captured in the resp cycle
    @(negedge clk);
    mem_wb_valid = 1'b1;
    mem_wb_reg   = mk_pl(mk(1, LD_F3_LB, WB_SEL_MEM, 1, 5'd12, 32'h0, 0, 32'h0, 32'h3003,
                            32'h0, 1, 32'h0), order_ctr);
    exp_q.push_back(order_ctr); order_ctr++;
    @(posedge clk);
    @(negedge clk);
    mem_wb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("lb_stall%0d_ready", k), 64'(wb_ready), 64'd0);
      check($sformatf("lb_stall%0d_commit", k), 64'(commit_valid), 64'd0);
      @(negedge clk);
    end
    dmem_resp    = 1'b1;
    dmem_rdata   = 32'h80FFFFFF;
    mem_wb_valid = 1'b1;
    mem_wb_reg   = mk_pl(alu_op(5'd6, 32'h55), order_ctr);
    exp_q.push_back(order_ctr); order_ctr++;
    #1;
    check("lb_resp_ready", 64'(wb_ready), 64'd1);
    check("lb_resp_commit", 64'(commit_valid), 64'd1);
    check("lb_resp_rd_v", 64'(rd_v), 64'hFFFFFF80);
    check("lb_resp_rd_s", 64'(rd_s), 64'd12);
    check("lb_resp_cnt", retired_cnt, exp_cnt);
    @(posedge clk); exp_cnt++;
    @(negedge clk);
    mem_wb_valid = 1'b0; dmem_resp = 1'b0;
    #1;
    check("after_lb_commit", 64'(commit_valid), 64'd1);
    check("after_lb_rd_v", 64'(rd_v), 64'h55);
    check("after_lb_rd_s", 64'(rd_s), 64'd6);
    @(posedge clk); exp_cnt++;
    @(negedge clk); #1;
    check("after_lb_idle", 64'(commit_valid), 64'd0);
    check("after_lb_cnt", retired_cnt, exp_cnt);

    // dmem_resp in EMPTY and HOLD is ignored; 4 back-to-back ALU ops
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    check("empty_resp_commit", 64'(commit_valid), 64'd0);
    check("empty_resp_state", 64'(dbg_state), 64'(EMPTY));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        mem_wb_valid = 1'b1;
        mem_wb_reg   = mk_pl(alu_op(5'(10 + i), 32'h100 + 32'(i)), order_ctr);
        exp_q.push_back(order_ctr); order_ctr++;
      end else begin
        mem_wb_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        check($sformatf("b2b%0d_commit", i - 1), 64'(commit_valid), 64'd1);
        check($sformatf("b2b%0d_rd_v", i - 1), 64'(rd_v), 64'h100 + 64'(i - 1));
        check($sformatf("b2b%0d_cnt", i - 1), retired_cnt, exp_cnt);
        exp_cnt++;
      end
      if (i < 4) check($sformatf("b2b%0d_ready", i), 64'(wb_ready), 64'd1);
    end
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check("b2b_idle", 64'(commit_valid), 64'd0);
    check("b2b_cnt", retired_cnt, exp_cnt);

    // Reset during WAIT drops the load; a late dmem_resp is ignored
    @(negedge clk);
    mem_wb_valid = 1'b1;
    mem_wb_reg   = mk_pl(mk(1, LD_F3_LW, WB_SEL_MEM, 1, 5'd4, 32'h0, 0, 32'h0, 32'h0,
                            32'h0, 1, 32'h0), 64'hDEAD);
    @(posedge clk);
    @(negedge clk);
    mem_wb_valid = 1'b0;
    #1;
    check("wait_state", 64'(dbg_state), 64'(WAIT));
    check("wait_ready", 64'(wb_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("wait_rst_ready", 64'(wb_ready), 64'd1);
    check("wait_rst_state", 64'(dbg_state), 64'(EMPTY));
    check("wait_rst_cnt", retired_cnt, 64'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    check("late_resp_commit", 64'(commit_valid), 64'd0);
    check("late_resp_rd_we", 64'(rd_we), 64'd0);
    check("late_resp_rd_v", 64'(rd_v), 64'd0);
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check("late_resp_state", 64'(dbg_state), 64'(EMPTY));
    check("late_resp_cnt", retired_cnt, 64'd0);

    // 17 commits: 4-bit counter wraps to 1, 64-bit counter reads 17
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i < 17) begin
        mem_wb_valid = 1'b1;
        mem_wb_reg   = mk_pl(alu_op(5'd1, 32'(i)), order_ctr);
        exp_q.push_back(order_ctr); order_ctr++;
      end else begin
        mem_wb_valid = 1'b0;
      end
    end
    @(negedge clk); #1;
    check("wrap_cnt_w4", 64'(w4_retired_cnt), 64'd1);
    check("wrap_cnt_w64", retired_cnt, 64'd17);

    @(negedge clk); #3;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
